// File: rtl/spi_embed_loader.sv
// spi_embed_loader
//   SPI-slave memory loader for embed mode. An external host shifts
//   write (and optionally read) frames in over spi_clk/spi_mosi while the
//   core is held disabled. Each frame becomes exactly one single-word
//   cycle on the req/ack master port. Completion is reported on spi_miso.
//
//   Frame (LSB first, sampled on spi_clk falling edges):
//     start(0) | addr[ADDR_W] | we | data[DATA_W] (writes only)
//   The host then keeps clocking with mosi=1 while miso=1, and gives one
//   more clock after miso goes 0.
//
//   Optional feature macro: SPI_EMBED_LOADER_READ_EN
//     defined   : we=0 frames run a bus read. miso then gives a 0 ready
//                 marker for one falling edge, followed by the read word
//                 LSB first.
//     undefined : we=0 frames go straight to DONE with no bus cycle.
//
//   Bus handshake: o_mem_req rises and then holds, with o_mem_addr,
//   o_mem_data and o_mem_we stable, until i_mem_ack or i_mem_err is seen
//   while req is high. req drops on the following cycle. ack and err
//   together count as err. ack/err while req is low are ignored.
//
// Ports
//   i_clk, i_rst_n    system clock, async active-low reset
//   i_spi_clk         host clock (idles high, async to i_clk)
//   i_spi_mosi        host data (idles high)
//   o_spi_miso        status / read data to host
//   o_mem_req/we/addr/data, i_mem_data/ack/err   bus master port
//   o_busy            frame in progress
//   o_err             sticky bus error flag
module spi_embed_loader #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_ack,
  input  logic              i_mem_err,
  output logic              o_busy,
  output logic              o_err
);

  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAXW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WE,
    S_DATA,
    S_WREQ,
    S_DONE
`ifdef SPI_EMBED_LOADER_READ_EN
    , S_RREQ,
    S_RDAT
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic                err_q, err_d;
  logic                miso_q, miso_d;
  logic [2:0]          sclk_q;
  logic [1:0]          mosi_q;
  logic                fe;
  logic                bit_in;
  logic                bus_done;

`ifdef SPI_EMBED_LOADER_READ_EN
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                marker_q, marker_d;
`else
  logic                unused_rdata;
  assign unused_rdata = ^i_mem_data;
`endif

  // Two-stage synchronisers; sclk_q[2] is the previous synchronised value
  // used for falling-edge detection. Reset to the idle-high level so a
  // reset never produces a phantom edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_q <= 3'b111;
      mosi_q <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], i_spi_clk};
      mosi_q <= {mosi_q[0], i_spi_mosi};
    end
  end

  assign fe       = sclk_q[2] & ~sclk_q[1];
  assign bit_in   = mosi_q[1];
  assign bus_done = req_q & (i_mem_ack | i_mem_err);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      miso_q   <= 1'b1;
`ifdef SPI_EMBED_LOADER_READ_EN
      rdata_q  <= '0;
      marker_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      req_q    <= req_d;
      err_q    <= err_d;
      miso_q   <= miso_d;
`ifdef SPI_EMBED_LOADER_READ_EN
      rdata_q  <= rdata_d;
      marker_q <= marker_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    req_d   = 1'b0;
    err_d   = err_q;
    miso_d  = 1'b1;
`ifdef SPI_EMBED_LOADER_READ_EN
    rdata_d  = rdata_q;
    marker_d = marker_q;
`endif
    case (state_q)
      S_IDLE: begin
        // mosi=1 edges are host init clocks and are ignored.
        if (fe && !bit_in) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (fe) begin
          // LSB first: shifting in from the top leaves bit 0 at addr[0].
          addr_d = {bit_in, addr_q[ADDR_W-1:1]};
          if (cnt_q == CNT_W'(ADDR_W - 1)) state_d = S_WE;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WE: begin
        if (fe) begin
          we_d  = bit_in;
          cnt_d = '0;
          if (bit_in) state_d = S_DATA;
`ifdef SPI_EMBED_LOADER_READ_EN
          else        state_d = S_RREQ;
`else
          else        state_d = S_DONE;
`endif
        end
      end
      S_DATA: begin
        if (fe) begin
          data_d = {bit_in, data_q[DATA_W-1:1]};
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_WREQ;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_WREQ: begin
        // Host polling clocks are ignored here.
        req_d = ~bus_done;
        if (bus_done) begin
          state_d = S_DONE;
          if (i_mem_err) err_d = 1'b1;
        end
      end
`ifdef SPI_EMBED_LOADER_READ_EN
      S_RREQ: begin
        req_d = ~bus_done;
        if (bus_done) begin
          state_d  = S_RDAT;
          rdata_d  = i_mem_data;
          marker_d = 1'b1;
          cnt_d    = '0;
          if (i_mem_err) err_d = 1'b1;
        end
      end
      S_RDAT: begin
        miso_d = marker_q ? 1'b0 : rdata_q[0];
        if (fe) begin
          if (marker_q) begin
            marker_d = 1'b0;
          end else begin
            rdata_d = rdata_q >> 1;
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_DONE;
            else                             cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      S_DONE: begin
        miso_d = 1'b0;
        if (fe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_spi_miso = miso_q;
  assign o_mem_req  = req_q;
  assign o_mem_we   = we_q;
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_spi_embed_loader.sv
module tb_spi_embed_loader;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected bus cycles in order.
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic              exp_we_q[$];

  // Responder configuration and state.
  int                ack_delay = 1;
  logic              use_err   = 1'b0;
  logic [DATA_W-1:0] rd_data   = '0;
  int                req_count = 0;
  logic              in_cycle  = 1'b0;
  logic              miso_low_seen = 1'b0;

  spi_embed_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_spi_clk  (spi_clk),
    .i_spi_mosi (spi_mosi),
    .o_spi_miso (spi_miso),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_wdata),
    .i_mem_data (mem_rdata),
    .i_mem_ack  (mem_ack),
    .i_mem_err  (mem_err),
    .o_busy     (busy),
    .o_err      (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic spi_bit(input logic b);
    @(negedge clk);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
  endtask

  // Same as spi_bit, but samples miso just before the falling edge.
  task automatic spi_bit_s(input logic b, output logic s);
    @(negedge clk);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    s = spi_miso;
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
  endtask

  task automatic send_header(input logic [ADDR_W-1:0] a, input logic we);
    spi_bit(1'b0);
    for (int i = 0; i < ADDR_W; i++) spi_bit(a[i]);
    spi_bit(we);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int dly, input logic e);
    int base;
    int n;
    base = req_count;
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
    exp_we_q.push_back(1'b1);
    ack_delay = dly;
    use_err = e;
    miso_low_seen = 1'b0;
    send_header(a, 1'b1);
    for (int i = 0; i < DATA_W; i++) spi_bit(d[i]);
    n = 0;
    while (!miso_low_seen && n < 100) begin
      spi_bit(1'b1);
      n++;
    end
    chk("miso_low_reached", miso_low_seen, 1);
    spi_bit(1'b1);
    repeat (6) @(negedge clk);
    chk("one_req_per_frame", req_count - base, 1);
    chk("idle_after_done", busy, 0);
    chk("miso_hi_in_idle", spi_miso, 1);
  endtask

  // Monitor: remembers that DONE status was presented to the host.
  initial begin
    forever begin
      @(negedge clk);
      if (busy && !spi_miso && !mem_req) miso_low_seen = 1'b1;
    end
  end

  // Bus responder with scoreboard compare on each new request.
  initial begin
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_data;
    logic              rec_we;
    int                wait_cnt;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !in_cycle) begin
        in_cycle = 1'b1;
        req_count++;
        rec_addr = mem_addr;
        rec_data = mem_wdata;
        rec_we   = mem_we;
        wait_cnt = ack_delay;
        if (exp_addr_q.size() == 0) begin
          chk("spurious_req", 1, 0);
        end else begin
          logic [ADDR_W-1:0] ea;
          logic [DATA_W-1:0] ed;
          logic              ew;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          ew = exp_we_q.pop_front();
          chk("req_addr", mem_addr, ea);
          chk("req_we", mem_we, ew);
          if (ew) chk("req_data", mem_wdata, ed);
        end
      end
      if (in_cycle) begin
        chk("addr_stable", mem_addr, rec_addr);
        chk("data_stable", mem_wdata, rec_data);
        chk("we_stable", mem_we, rec_we);
        chk("req_held", mem_req, 1);
        if (wait_cnt == 0) begin
          chk("miso_hi_at_ack", spi_miso, 1);
          mem_ack   = ~use_err;
          mem_err   = use_err;
          mem_rdata = rd_data;
          @(negedge clk);
          mem_ack = 1'b0;
          mem_err = 1'b0;
          chk("req_dropped", mem_req, 0);
          chk("miso_hi_ack_plus1", spi_miso, 1);
          @(negedge clk);
          chk("miso_lo_ack_plus2", spi_miso, 0);
          in_cycle = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Directed sequence
  initial begin
    logic s;
    logic [DATA_W-1:0] rbits;
    int base;
    int n;
    rst_n    = 1'b0;
    spi_clk  = 1'b1;
    spi_mosi = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_miso", spi_miso, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write, quick ack.
    do_write(24'h800011, 16'h3888, 1, 1'b0);

    // Same write, ack delayed while host keeps clocking.
    do_write(24'h800011, 16'h3888, 20, 1'b0);

    // Init clocks then back-to-back frames.
    base = req_count;
    spi_bit(1'b1);
    spi_bit(1'b1);
    repeat (6) @(negedge clk);
    chk("init_clocks_idle", busy, 0);
    chk("init_clocks_no_req", req_count - base, 0);
    for (int i = 0; i < 4; i++)
      do_write(24'h800000 + 24'(i), 16'hA000 + 16'(i * 16'h0111), 1, 1'b0);

    // Reset mid-frame, then a full frame.
    spi_bit(1'b0);
    for (int i = 0; i < 10; i++) spi_bit(1'b1);
    chk("midframe_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_miso", spi_miso, 1);
    chk("midrst_req", mem_req, 0);
    chk("midrst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_write(24'h800020, 16'h0024, 1, 1'b0);
    chk("err_clear_after_rst", err, 0);

    // Bus error is sticky across a good frame.
    do_write(24'h800005, 16'hBEEF, 2, 1'b1);
    chk("err_set", err, 1);
    do_write(24'h800006, 16'h1234, 1, 1'b0);
    chk("err_sticky", err, 1);

    // we=0 frame.
    base = req_count;
`ifdef SPI_EMBED_LOADER_READ_EN
    exp_addr_q.push_back(24'h800010);
    exp_data_q.push_back('0);
    exp_we_q.push_back(1'b0);
    ack_delay = 1;
    use_err   = 1'b0;
    rd_data   = 16'h0004;
    send_header(24'h800010, 1'b0);
    n = 0;
    while ((req_count == base || in_cycle) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("read_req_done", (req_count == base || in_cycle) ? 1 : 0, 0);
    repeat (3) @(negedge clk);
    chk("read_marker", spi_miso, 0);
    spi_bit(1'b1);
    for (int i = 0; i < DATA_W; i++) begin
      spi_bit_s(1'b1, s);
      rbits[i] = s;
    end
    chk("read_bits", rbits, 16'h0004);
    repeat (4) @(negedge clk);
    chk("read_done_miso", spi_miso, 0);
    chk("read_done_busy", busy, 1);
    spi_bit(1'b1);
    repeat (6) @(negedge clk);
    chk("read_idle", busy, 0);
    chk("read_one_req", req_count - base, 1);
`else
    send_header(24'h800010, 1'b0);
    repeat (8) @(negedge clk);
    chk("noread_miso_low", spi_miso, 0);
    chk("noread_busy", busy, 1);
    chk("noread_no_req", req_count - base, 0);
    spi_bit(1'b1);
    repeat (6) @(negedge clk);
    chk("noread_idle", busy, 0);
    chk("noread_miso_hi", spi_miso, 1);
`endif
    rbits = '0;
    s = 1'b0;

    chk("scoreboard_empty", exp_addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
